// File: rtl/req_arbiter16.sv
// 16-requester arbiter: round-robin or fixed-priority selection, grant held until release.
// Optional hold-time limit enabled by defining ARB_TIMEOUT_EN.
module req_arbiter16 #(
   parameter int unsigned N       = 16,
   parameter int unsigned IDX_W   = 4,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   input  logic             prio_mode,
   output logic [N-1:0]     gnt,
   output logic             gnt_valid,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             timeout
);

   typedef enum logic [1:0] {StIdle, StBusy, StRel} state_e;

   state_e           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             mode_q, mode_d;

   logic [N-1:0]     req_hi;
   logic [IDX_W-1:0] fix_w, hi_w, win;
   logic             release_norm;
   logic             expire;

   // Lowest set bit overall, and lowest set bit at or above the round-robin pointer.
   always_comb begin
      req_hi = '0;
      fix_w  = '0;
      hi_w   = '0;
      for (int i = 0; i < int'(N); i++) begin
         req_hi[i] = req[i] && (i >= int'(ptr_q));
      end
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (req[i])    fix_w = IDX_W'(i);
         if (req_hi[i]) hi_w  = IDX_W'(i);
      end
      if (prio_mode)     win = fix_w;
      else if (|req_hi)  win = hi_w;
      else               win = fix_w;
   end

   assign release_norm = done || !req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;

   assign expire = (cnt_q == CntW'(TIMEOUT - 1));

   always_comb begin
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      if (state_q == StIdle) begin
         cnt_d = '0;
      end else if (state_q == StBusy) begin
         cnt_d     = cnt_q + CntW'(1);
         // A simultaneous done wins: that is an ordinary release, not a timeout.
         timeout_d = expire && !release_norm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign expire         = 1'b0;
   assign timeout        = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      gnt_idx_d   = gnt_idx_q;
      ptr_d       = ptr_q;
      mode_d      = mode_q;
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               gnt_d       = N'(1) << win;
               gnt_idx_d   = win;
               gnt_valid_d = 1'b1;
               mode_d      = prio_mode;
               state_d     = StBusy;
            end
         end
         StBusy: begin
            if (release_norm || expire) begin
               gnt_d       = '0;
               gnt_valid_d = 1'b0;
               // Mode captured at grant time decides rotation, not the live input.
               if (!mode_q) ptr_d = gnt_idx_q + IDX_W'(1);
               state_d     = StRel;
            end
         end
         StRel: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= '0;
         ptr_q       <= '0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_idx_q   <= gnt_idx_d;
         ptr_q       <= ptr_d;
         mode_q      <= mode_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_idx   = gnt_idx_q;

endmodule
